// File: rtl/dct_cos_coef_gen.sv
// Streams cos((2n1+1)k1*pi/2N)*cos((2n2+1)k2*pi/2N) for one (k1,k2) pair over the NxN grid.
// Three-stage pipeline (quarter-wave fold, magnitude multiply, scale/sign) under one global enable.
//
// state | meaning
// IDLE  | waiting for a start handshake, start_ready high
// RUN   | issuing one (n1,n2) index per enabled cycle, raster order
// DRAIN | all indices issued, waiting for the out_last beat to handshake
module dct_cos_coef_gen #(
  parameter int N         = 8,
  parameter int FRAC_BITS = 8,
  parameter int OUT_W     = 32,
  parameter int ROM_FRAC  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [$clog2(N)-1:0] k1,
  input  logic [$clog2(N)-1:0] k2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     cos_term,
  output logic [$clog2(N)-1:0] out_n1,
  output logic [$clog2(N)-1:0] out_n2,
  output logic                 out_last,
  output logic                 busy
);

  localparam int  IW = $clog2(N);
  localparam int  RW = ROM_FRAC + 1;
  localparam int  PW = 2 * RW;
  localparam int  SH = 2 * ROM_FRAC - FRAC_BITS;
  localparam int  XW = (OUT_W > PW) ? OUT_W : PW;
  localparam real PI = 3.14159265358979323846;

  // Elaboration-time cosine via Taylor series; the argument never exceeds pi/2.
  function automatic logic [RW-1:0] rom_val(input int j);
    real x;
    real term;
    real sum;
    int  v;
    if (j == 0) return RW'(1) << ROM_FRAC;
    if (j >= N) return '0;
    x    = real'(j) * PI / real'(2 * N);
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i <= 14; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    v = $rtoi(sum * real'(1 << ROM_FRAC));
    return RW'(v);
  endfunction

  // ((2n+1)*k) mod 4N; 4N is a power of two so the product simply wraps.
  function automatic logic [IW+1:0] phase(input logic [IW-1:0] n, input logic [IW-1:0] k);
    return (IW+2)'({n, 1'b1}) * (IW+2)'(k);
  endfunction

  // Quadrants 1 and 3 read the ROM mirrored (N - r); quadrants 0 and 2 read it directly.
  function automatic logic [IW:0] fold_idx(input logic [IW+1:0] m);
    logic [IW-1:0] r;
    r = m[IW-1:0];
    if (m[IW]) return (IW+1)'(N) - {1'b0, r};
    return {1'b0, r};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  logic [RW-1:0] rom [0:N];
  for (genvar j = 0; j <= N; j++) begin : g_rom
    assign rom[j] = rom_val(j);
  end

  state_t        state;
  logic [IW-1:0] k1_r, k2_r, n1, n2;
  logic          en, last_idx;
  logic [IW+1:0] m1, m2;
  logic [IW:0]   i1, i2;

  logic          s1_v, s1_last, s1_sg1, s1_sg2;
  logic [IW-1:0] s1_n1, s1_n2;
  logic [RW-1:0] s1_mag1, s1_mag2;
  logic          s2_v, s2_last, s2_sgn;
  logic [IW-1:0] s2_n1, s2_n2;
  logic [PW-1:0] s2_prod;

  assign en          = ~out_valid | out_ready;
  assign last_idx    = (n1 == IW'(N - 1)) && (n2 == IW'(N - 1));
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  always_comb begin
    m1 = phase(n1, k1_r);
    m2 = phase(n2, k2_r);
    i1 = fold_idx(m1);
    i2 = fold_idx(m2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k1_r      <= '0;
      k2_r      <= '0;
      n1        <= '0;
      n2        <= '0;
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      s1_sg1    <= 1'b0;
      s1_sg2    <= 1'b0;
      s1_n1     <= '0;
      s1_n2     <= '0;
      s1_mag1   <= '0;
      s1_mag2   <= '0;
      s2_v      <= 1'b0;
      s2_last   <= 1'b0;
      s2_sgn    <= 1'b0;
      s2_n1     <= '0;
      s2_n2     <= '0;
      s2_prod   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_n1    <= '0;
      out_n2    <= '0;
      cos_term  <= '0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          k1_r  <= k1;
          k2_r  <= k2;
          n1    <= '0;
          n2    <= '0;
          state <= RUN;
        end
        RUN: if (en) begin
          if (n2 == IW'(N - 1)) begin
            n2 <= '0;
            n1 <= n1 + IW'(1);
            if (n1 == IW'(N - 1)) state <= DRAIN;
          end else begin
            n2 <= n2 + IW'(1);
          end
        end
        DRAIN: if (out_valid && out_ready && out_last) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (en) begin
        s1_v      <= (state == RUN);
        s1_last   <= last_idx;
        s1_n1     <= n1;
        s1_n2     <= n2;
        s1_mag1   <= rom[i1];
        s1_mag2   <= rom[i2];
        s1_sg1    <= m1[IW+1] ^ m1[IW];
        s1_sg2    <= m2[IW+1] ^ m2[IW];

        s2_v      <= s1_v;
        s2_last   <= s1_last;
        s2_n1     <= s1_n1;
        s2_n2     <= s1_n2;
        s2_prod   <= PW'(s1_mag1) * PW'(s1_mag2);
        s2_sgn    <= s1_sg1 ^ s1_sg2;

        // Shift truncates toward zero; negating a zero magnitude leaves zero.
        out_valid <= s2_v;
        out_last  <= s2_last;
        out_n1    <= s2_n1;
        out_n2    <= s2_n2;
        cos_term  <= OUT_W'(s2_sgn ? -(XW'(s2_prod) >> SH) : (XW'(s2_prod) >> SH));
      end
    end
  end

endmodule

// File: tb/tb_dct_cos_coef_gen.sv
// Scoreboard bench for dct_cos_coef_gen: stimulus pushes expected beats, a monitor pops and compares.
module tb_dct_cos_coef_gen;

  localparam int  N  = 8;
  localparam int  IW = 3;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [IW-1:0] k1 = '0;
  logic [IW-1:0] k2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   cos_term;
  logic [IW-1:0] out_n1, out_n2;
  logic          out_last;
  logic          busy;

  dct_cos_coef_gen #(.N(N), .FRAC_BITS(8), .OUT_W(32), .ROM_FRAC(16)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .k1(k1), .k2(k2), .out_valid(out_valid), .out_ready(out_ready),
    .cos_term(cos_term), .out_n1(out_n1), .out_n2(out_n2), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n1;
    int          n2;
    logic        last;
    logic [31:0] val;
  } exp_t;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          hs_count = 0;
  int          last_hs_edge = 0;
  int          n_acc = 0;
  exp_t        sb[$];
  logic [31:0] cap [64];
  bit          chk_idle = 0;
  bit          prev_stall = 0;
  logic [31:0] p_cos;
  logic [IW-1:0] p_n1, p_n2;
  logic        p_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Fixed-point golden: |cos| quantised to 16 fractional bits per axis, product floored to 8.
  function automatic logic [31:0] model(input int ka, input int kb, input int na, input int nb);
    real    a, b;
    int     qa, qb;
    longint mag;
    bit     neg;
    a   = $cos(real'((2 * na + 1) * ka) * PI / real'(2 * N));
    b   = $cos(real'((2 * nb + 1) * kb) * PI / real'(2 * N));
    qa  = $rtoi((a < 0.0 ? -a : a) * 65536.0);
    qb  = $rtoi((b < 0.0 ? -b : b) * 65536.0);
    mag = (longint'(qa) * longint'(qb)) >>> 24;
    neg = (a < 0.0) != (b < 0.0);
    if (neg) mag = -mag;
    return mag[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input int ka, input int kb);
    exp_t e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        e.n1 = i;
        e.n2 = j;
        e.last = (i == N - 1) && (j == N - 1);
        e.val = model(ka, kb, i, j);
        sb.push_back(e);
      end
  endtask

  task automatic start(input int ka, input int kb, input bit hold);
    bit acc = 0;
    int guard = 0;
    start_valid = 1'b1;
    k1 = IW'(ka);
    k2 = IW'(kb);
    while (!acc && guard < 300) begin
      acc = start_ready;
      tick();
      guard++;
    end
    if (!acc) begin
      n_assert++;
      n_fail++;
      $display("FAIL start_timeout: k1=%0d k2=%0d never accepted", ka, kb);
    end
    push_set(ka, kb);
    hs_count = 0;
    if (!hold) start_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while ((sb.size() != 0 || busy) && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, busy=%0b", sb.size(), busy);
    end
  endtask

  task automatic wait_beats(input int cnt);
    int guard = 0;
    while (hs_count < cnt && guard < 500) begin
      tick();
      guard++;
    end
    if (guard >= 500) begin
      n_assert++;
      n_fail++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", hs_count, cnt);
    end
  endtask

  task automatic check_k41_table();
    check("c(0,0)", cap[0],  32'h000000B1);
    check("c(0,1)", cap[1],  32'h00000096);
    check("c(0,3)", cap[3],  32'h00000023);
    check("c(0,4)", cap[4],  32'hFFFFFFDD);
    check("c(1,0)", cap[8],  32'hFFFFFF4F);
    check("c(3,7)", cap[31], 32'hFFFFFF4F);
    check("c(7,7)", cap[63], 32'hFFFFFF4F);
    check("beat_count", 32'(hs_count), 32'd64);
  endtask

  // Monitor: hold-while-stalled, scoreboard pop on handshake, idle after the last beat.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_stall = 0;
      chk_idle = 0;
    end else begin
      if (start_valid && start_ready) n_acc++;
      if (chk_idle) begin
        check("idle_after_last", {30'd0, busy, start_ready}, 32'd1);
        chk_idle = 0;
      end
      if (prev_stall) begin
        check("stall_hold", {out_valid, out_last, 24'd0, out_n1, out_n2},
              {1'b1, p_last, 24'd0, p_n1, p_n2});
        check("stall_hold_val", cos_term, p_cos);
      end
      if (out_valid && out_ready) begin
        n_assert++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got (%0d,%0d)=%h with no beat expected",
                   out_n1, out_n2, cos_term);
        end else begin
          e = sb.pop_front();
          if (cos_term !== e.val || out_n1 !== IW'(e.n1) || out_n2 !== IW'(e.n2) ||
              out_last !== e.last) begin
            n_fail++;
            $display("FAIL beat: got (%0d,%0d)=%h last=%0b expected (%0d,%0d)=%h last=%0b",
                     out_n1, out_n2, cos_term, out_last, e.n1, e.n2, e.val, e.last);
          end
          cap[{out_n1, out_n2}] = cos_term;
          hs_count++;
          if (out_last) begin
            last_hs_edge = cyc + 1;
            chk_idle = 1;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      p_cos  = cos_term;
      p_n1   = out_n1;
      p_n2   = out_n2;
      p_last = out_last;
    end
  end

  initial begin
    int lat;
    int guard;
    int acc_base;
    int acc_edge;
    bit acc;

    #2 reset = 1'b1;
    repeat (3) tick();
    check("rst_outs", {28'd0, out_valid, out_last, busy, start_ready}, 32'd1);
    check("rst_cos", cos_term, 32'd0);
    check("rst_idx", {26'd0, out_n1, out_n2}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst", {30'd0, busy, start_ready}, 32'd1);

    // 1: k1=4 k2=1 at full throughput, first beat three edges after the start edge
    start(4, 1, 0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    wait_done();
    check_k41_table();

    // 2: DC pair yields exactly 1.0 everywhere
    start(0, 0, 0);
    wait_done();
    for (int i = 0; i < 64; i++) check("dc_value", cap[i], 32'h00000100);

    // 3: five-cycle stall at beat 10, then random backpressure
    start(4, 1, 0);
    wait_beats(10);
    out_ready = 1'b0;
    repeat (5) tick();
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    out_ready = 1'b1;
    wait_done();
    check_k41_table();

    // 4: start_valid held high, k changed mid-run, back-to-back restart
    acc_base = n_acc;
    start(4, 1, 1);
    repeat (10) tick();
    k1 = 3'd2;
    k2 = 3'd3;
    acc = 0;
    acc_edge = 0;
    guard = 0;
    while (!acc && guard < 300) begin
      acc = start_ready && start_valid;
      acc_edge = cyc + 1;
      tick();
      guard++;
    end
    check("restart_gap", 32'(acc_edge), 32'(last_hs_edge + 1));
    push_set(2, 3);
    hs_count = 0;
    start_valid = 1'b0;
    wait_done();
    check("accept_count", 32'(n_acc - acc_base), 32'd2);

    // 5: reset during beat 20 discards the partial set
    start(4, 1, 0);
    wait_beats(20);
    reset = 1'b1;
    #1;
    check("midrst_outs", {30'd0, out_valid, busy}, 32'd0);
    sb.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("midrst_ready", {31'd0, start_ready}, 32'd1);
    start(4, 1, 0);
    wait_done();
    check_k41_table();

    // 6: sweep every frequency pair against the golden model
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) begin
        start(a, b, 0);
        wait_done();
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dct_cos_coef_gen.md
Name: dct_cos_coef_gen

Overview:
- Streams the 2D DCT cosine coefficients for one (k1,k2) frequency pair over the full NxN sample grid.
- Each coefficient is cos((2n1+1)k1π/2N)·cos((2n2+1)k2π/2N), signed fixed point with FRAC_BITS fractional bits.
- Replaces one hard-coded combinational table per (k1,k2) with a single parametrised, pipelined generator built from one quarter-wave ROM and one multiplier.
- Feeds the DCT multiply-accumulate datapath through a valid/ready stream.

Parameters:
- N, 8, block dimension; power of two, 4..32.
- FRAC_BITS, 8, fractional bits of cos_term.
- OUT_W, 32, cos_term width; two's complement.
- ROM_FRAC, 16, fractional bits of the internal 1D cosine ROM.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start_valid  in  1  request to generate one coefficient set.
- start_ready  out  1  high only in IDLE.
- k1  in  $clog2(N)  row frequency; sampled on the start handshake.
- k2  in  $clog2(N)  column frequency; sampled on the start handshake.
- out_valid  out  1  cos_term, out_n1, out_n2 and out_last are valid.
- out_ready  in  1  consumer accepts the current output.
- cos_term  out  OUT_W  signed coefficient.
- out_n1  out  $clog2(N)  n1 index of cos_term.
- out_n2  out  $clog2(N)  n2 index of cos_term.
- out_last  out  1  marks coefficient (N-1,N-1).
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid, out_last, busy = 0; cos_term, out_n1, out_n2 = 0; counters and pipeline valids = 0; start_ready = 1.
- FSM states:
  - IDLE: start_valid & start_ready latches k1,k2, clears n1,n2, goes to RUN.
  - RUN: issues one index per enabled cycle in raster order (n2 inner, n1 outer). After issuing (N-1,N-1), goes to DRAIN.
  - DRAIN: no issue. Returns to IDLE on the edge where the out_last beat handshakes.
- start_valid outside IDLE is ignored. A new start can be accepted in the cycle after the out_last handshake.
- Pipeline is three register stages with a global enable en = ~out_valid | out_ready. All stages and the index counter advance only when en = 1.
  - S1: m = ((2n+1)·k) mod 4N, computed for each axis. Quarter-wave fold, with rom[j] = floor(cos(jπ/2N)·2^ROM_FRAC) for j = 0..N, rom[0] = 2^ROM_FRAC, rom[N] = 0:
    - m < N: +rom[m]
    - N ≤ m < 2N: −rom[2N−m]
    - 2N ≤ m < 3N: −rom[m−2N]
    - 3N ≤ m < 4N: +rom[4N−m]
    - Registers magnitude and sign per axis.
  - S2: unsigned product of the two magnitudes (2·ROM_FRAC+2 bits); sign = XOR of the axis signs.
  - S3: magnitude = product >> (2·ROM_FRAC − FRAC_BITS), truncated toward zero. Negated if the sign is set and the magnitude is nonzero, then sign-extended to OUT_W. Indices and last flag travel alongside each stage.
- ROM contents are fixed at elaboration from N and ROM_FRAC.
- No α(k) normalisation is applied. k=0 yields exactly 1.0, i.e. 2^FRAC_BITS.
- Latency: the first out_valid is registered 3 clock edges after the start-accepting edge. Throughput is 1 coefficient per clock when out_ready = 1.
- While out_valid & ~out_ready, all outputs hold stable; there is no loss or duplication.
- Async reset mid-stream clears immediately. The partial set is discarded and the next start restarts at (0,0).

Test Plan:
1. k1=4, k2=1, out_ready=1:
   - 64 beats; first out_valid 3 clocks after the start edge.
   - (0,0)=0x000000B1, (0,1)=0x96, (0,3)=0x23, (0,4)=0xFFFFFFDD, (1,0)=0xFFFFFF4F, (3,7)=0xFFFFFF4F, (7,7)=0xFFFFFF4F with out_last=1.
   - busy drops and start_ready rises the cycle after the last handshake.
2. k1=0, k2=0 → all 64 cos_term = 0x00000100.
3. k1=4, k2=1, out_ready low for 5 cycles at beat 10 and then toggled randomly → outputs stable while stalled; the 64 beats are in raster order with no gaps or duplicates; values match scenario 1.
4. start_valid held high throughout → exactly one start accepted per set; (k1,k2) changed during RUN does not affect the current set; the second set starts at (0,0) immediately after the first out_last.
5. reset asserted during beat 20, released 2 cycles later → out_valid=0 and busy=0 immediately; start_ready=1 after release; a new start (k1=4, k2=1) produces the scenario 1 stream from (0,0).
6. Sweep all 64 (k1,k2) pairs, N=8, FRAC_BITS=8 → every beat equals sign·floor(|cos·cos|·256) from a real-valued golden model.
